button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Debounces one mechanical push-button or switch input.
- Synchronizes the raw input to the system clock and samples it on an internally generated slow tick, the same divided-rate timebase the board divider provides.
- Declares a new level only after the sampled value holds for a programmable number of consecutive ticks.
- Outputs the clean level plus one-cycle press and release strobes; these feed the FSM's step and reset controls.

Parameters:
- TICK_DIV, 100000: system clocks per sample tick (500 Hz at 50 MHz). Minimum 2.
- STABLE_SAMPLES, 4: consecutive identical samples required to change the debounced level. Minimum 2.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button/switch level.
- db_level  output  1  debounced level, registered.
- rise_pulse  output  1  one clk_in cycle high when db_level goes 0->1.
- fall_pulse  output  1  one clk_in cycle high when db_level goes 1->0.
- sample_tick  output  1  internal tick strobe, exported for observation and chaining.

Behaviour:
- Reset (synchronous, sampled on a clk_in edge) clears:
  - both synchronizer flops;
  - tick counter;
  - stable counter;
  - state to IDLE_LOW;
  - db_level, rise_pulse, fall_pulse, sample_tick, all to 0.
- Reset overrides every other event in the same cycle, including a coincident tick.
- Synchronizer: two flops, btn_in -> s1 -> s2. The FSM uses only s2 (2-cycle input latency).
- Tick counter:
  - Width is clog2(TICK_DIV).
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - sample_tick is registered and high for exactly the one cycle after the counter reaches TICK_DIV-1, giving a period of TICK_DIV cycles.
  - Free-running; it does not restart on input activity.
- Stable counter: width clog2(STABLE_SAMPLES+1); saturates and never wraps.
- The FSM advances only in cycles where sample_tick=1; otherwise it holds state and counters.
- IDLE_LOW (db_level=0):
  - s2=1 -> WAIT_HIGH, cnt=1.
  - s2=0 -> stay.
- WAIT_HIGH:
  - s2=1 and cnt+1==STABLE_SAMPLES -> IDLE_HIGH, db_level=1, rise_pulse=1 next cycle.
  - s2=1 otherwise -> cnt++.
  - s2=0 -> IDLE_LOW, cnt=0, no pulse.
- IDLE_HIGH (db_level=1):
  - s2=0 -> WAIT_LOW, cnt=1.
  - s2=1 -> stay.
- WAIT_LOW: mirror of WAIT_HIGH.
  - Completion -> IDLE_LOW, db_level=0, fall_pulse=1.
  - Any s2=1 sample -> back to IDLE_HIGH, no pulse.
- Pulse timing:
  - rise_pulse/fall_pulse are high for exactly one cycle, in the same cycle db_level first shows the new value.
  - They are never high simultaneously.
  - They are never asserted while not in the tick-following cycle.
- Latency from a clean edge on btn_in to the db_level change:
  - minimum 2 + (STABLE_SAMPLES-1)*TICK_DIV + 1 cycles;
  - maximum is that plus TICK_DIV-1.
- Glitches shorter than one tick period between samples are invisible by construction.
- Input changes between ticks are ignored; only the tick-aligned s2 value counts.
- Reset during WAIT_HIGH/WAIT_LOW: no pulse is emitted, and the next state is IDLE_LOW even if db_level was 1.

Test Plan (TICK_DIV=4, STABLE_SAMPLES=3):
- Reset held 3 cycles, then btn_in=0 for 40 cycles:
  - db_level, rise_pulse and fall_pulse stay 0.
  - sample_tick pulses every 4th cycle.
- btn_in 0->1 held clean:
  - db_level=1 with rise_pulse=1 for one cycle, on the cycle after the third consecutive high-sampling tick.
  - That is between 11 and 14 cycles after the edge.
  - rise_pulse then returns to 0.
- From db_level=1, btn_in set 0 and held:
  - fall_pulse=1 for one cycle, and db_level=0 in the same cycle.
  - Same latency window as the press case.
- Bounce: btn_in toggled every 5 cycles for 60 cycles, then held at 1:
  - No pulses and db_level=0 during the bounce.
  - Exactly one rise_pulse after the hold.
- Two high samples, then one low sample at a tick:
  - FSM returns to IDLE_LOW and no rise_pulse occurs.
  - A fresh 3-sample run is then required before rise_pulse.
- Reset asserted while in WAIT_LOW with db_level=1:
  - Next cycle db_level=0, no fall_pulse, tick counter restarts from 0.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, free-running sample tick and a
// four-state FSM that commits a new level after STABLE_SAMPLES matching samples.
module button_debouncer #(
   parameter int TICK_DIV       = 100000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic clk_in,
   input  logic reset,
   input  logic btn_in,
   output logic db_level,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic sample_tick
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_SAMPLES + 1);

   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_ONE = TW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_SAMPLES);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   logic          s1_r;
   logic          s2_r;
   logic [TW-1:0] tick_cnt_r;
   logic          sample_tick_r;
   logic [CW-1:0] stable_cnt_r;
   state_t        state_r;
   logic          db_level_r;
   logic          rise_pulse_r;
   logic          fall_pulse_r;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= btn_in;
         s2_r <= s1_r;
      end
   end

   // Free-running divider; the tick strobe lands in the cycle after the wrap value.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         tick_cnt_r    <= '0;
         sample_tick_r <= 1'b0;
      end else begin
         if (tick_cnt_r == TICK_MAX) begin
            tick_cnt_r <= '0;
         end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
         end
         sample_tick_r <= (tick_cnt_r == TICK_MAX);
      end
   end

   // Debounce FSM; pulses default low so each lasts exactly one cycle.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_r      <= IDLE_LOW;
         stable_cnt_r <= CNT_ZERO;
         db_level_r   <= 1'b0;
         rise_pulse_r <= 1'b0;
         fall_pulse_r <= 1'b0;
      end else begin
         rise_pulse_r <= 1'b0;
         fall_pulse_r <= 1'b0;
         if (sample_tick_r) begin
            case (state_r)
               IDLE_LOW: begin
                  if (s2_r) begin
                     state_r      <= WAIT_HIGH;
                     stable_cnt_r <= CNT_ONE;
                  end
               end
               WAIT_HIGH: begin
                  if (!s2_r) begin
                     state_r      <= IDLE_LOW;
                     stable_cnt_r <= CNT_ZERO;
                  end else if (stable_cnt_r == CNT_LAST) begin
                     state_r      <= IDLE_HIGH;
                     stable_cnt_r <= CNT_ZERO;
                     db_level_r   <= 1'b1;
                     rise_pulse_r <= 1'b1;
                  end else if (stable_cnt_r != CNT_MAX) begin
                     stable_cnt_r <= stable_cnt_r + CNT_ONE;
                  end
               end
               IDLE_HIGH: begin
                  if (!s2_r) begin
                     state_r      <= WAIT_LOW;
                     stable_cnt_r <= CNT_ONE;
                  end
               end
               WAIT_LOW: begin
                  if (s2_r) begin
                     state_r      <= IDLE_HIGH;
                     stable_cnt_r <= CNT_ZERO;
                  end else if (stable_cnt_r == CNT_LAST) begin
                     state_r      <= IDLE_LOW;
                     stable_cnt_r <= CNT_ZERO;
                     db_level_r   <= 1'b0;
                     fall_pulse_r <= 1'b1;
                  end else if (stable_cnt_r != CNT_MAX) begin
                     stable_cnt_r <= stable_cnt_r + CNT_ONE;
                  end
               end
               default: begin
                  state_r      <= IDLE_LOW;
                  stable_cnt_r <= CNT_ZERO;
                  db_level_r   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign db_level    = db_level_r;
   assign rise_pulse  = rise_pulse_r;
   assign fall_pulse  = fall_pulse_r;
   assign sample_tick = sample_tick_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with TICK_DIV=4, STABLE_SAMPLES=3:
// a vector table for the main scenarios plus hand sequences for abort and mid-wait reset.
module tb_button_debouncer;

   logic clk_in;
   logic reset;
   logic btn_in;
   logic db_level;
   logic rise_pulse;
   logic fall_pulse;
   logic sample_tick;

   int total;
   int bad;
   int vec_idx;
   int tcount;

   typedef struct {
      logic rst;
      logic btn;
      int   n;
      logic db;
      logic rise;
      logic fall;
   } vec_t;

   vec_t tbl[$];

   button_debouncer #(
      .TICK_DIV       (4),
      .STABLE_SAMPLES (3)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .btn_in      (btn_in),
      .db_level    (db_level),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .sample_tick (sample_tick)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d got=%b want=%b", name, vec_idx, act, exp);
      end
   endtask

   // Apply one input pair for n cycles; check outputs #1 after each rising edge.
   task automatic run(input logic rst, input logic btn, input int n,
                      input logic db, input logic rise, input logic fall);
      logic exp_tick;
      for (int i = 0; i < n; i++) begin
         reset  = rst;
         btn_in = btn;
         @(posedge clk_in);
         #1;
         if (rst) begin
            exp_tick = 1'b0;
            tcount   = 0;
         end else begin
            exp_tick = ((tcount % 4) == 3);
            tcount++;
         end
         chk("db_level", db_level, db);
         chk("rise_pulse", rise_pulse, rise);
         chk("fall_pulse", fall_pulse, fall);
         chk("sample_tick", sample_tick, exp_tick);
         vec_idx++;
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      vec_idx = 0;
      tcount  = 0;
      reset   = 1'b1;
      btn_in  = 1'b0;

      // reset, then idle low
      tbl.push_back('{1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b0});
      // clean press: rise 13 cycles after the edge
      tbl.push_back('{1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 7,  1'b1, 1'b0, 1'b0});
      // clean release
      tbl.push_back('{1'b0, 1'b0, 12, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 7,  1'b0, 1'b0, 1'b0});
      // bounce: toggle every 5 cycles for 60 cycles, never three highs in a row
      for (int p = 0; p < 6; p++) begin
         tbl.push_back('{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0});
         tbl.push_back('{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0});
      end
      // hold high after bounce: exactly one rise
      tbl.push_back('{1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b0});
      // release back to low
      tbl.push_back('{1'b0, 1'b0, 12, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0});

      foreach (tbl[k]) begin
         run(tbl[k].rst, tbl[k].btn, tbl[k].n, tbl[k].db, tbl[k].rise, tbl[k].fall);
      end

      // Abort: two high samples then a low sample; a fresh 3-sample run is needed.
      run(1'b0, 1'b1, 8,  1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0);
      run(1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b0);

      // Reset while in WAIT_LOW with db_level=1, on a cycle that would raise the tick.
      run(1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0);
      run(1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
